// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the bus-1 memory arbiter.
// Holds the lock FSM state encodings (used only when ARB_LOCK_EN is defined)
// and a helper that gives the minimum requester-index width.
package mem_bus_arbiter_pkg;

  // Lock FSM states: IDLE arbitrates freely, LOCKED restricts grants to the owner.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Minimum width of a requester index for num_req requesters (at least 1 bit).
  function automatic int unsigned req_idx_width(input int unsigned num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: scans req starting at ptr, wrapping modulo NUM_REQ,
// and reports the first asserted bit as a one-hot vector and as an index.
// Purely combinational so it can be reused for other round-robin pickers.
module rr_priority_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  localparam int unsigned SumW = ID_W + 1;

  logic [SumW-1:0] sum;
  logic [ID_W-1:0] pos;

  // Walk offsets 0..NUM_REQ-1 from ptr; the first offset whose position requests wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SumW'(i);
      if (sum >= SumW'(NUM_REQ)) begin
        sum = sum - SumW'(NUM_REQ);
      end
      pos = sum[ID_W-1:0];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_any && (pos == ID_W'(j)) && req[j]) begin
          gnt_any   = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing memory bus 1 among NUM_REQ requesters.
// Muxes the winner onto the memory port, tracks the 1-cycle read latency and
// returns read data with a per-requester rvalid strobe.
// Optional feature macro: ARB_LOCK_EN (bus lock for atomic read-modify-write).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   wr,
  input  logic [NUM_REQ*N-1:0] addr,
  input  logic [NUM_REQ*N-1:0] din,
  input  logic [NUM_REQ-1:0]   lock,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rvalid,
  output logic [N-1:0]         rdata,
  output logic                 mem_wr_ena,
  output logic [N-1:0]         mem_addr,
  output logic [N-1:0]         mem_din,
  input  logic [N-1:0]         mem_dout
);

  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

  // Index of the requester after v, wrapping the last requester back to 0.
  function automatic logic [ID_W-1:0] idx_inc(input logic [ID_W-1:0] v);
    return (v == LastIdx) ? '0 : v + ID_W'(1);
  endfunction

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               gnt_any;
  logic               win_wr;
  logic [N-1:0]       win_addr;
  logic [N-1:0]       win_din;
  logic [N-1:0]       mem_addr_q;
  logic [N-1:0]       mem_din_q;
  logic               rd_pend_q, rd_pend_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_eff),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Nothing is granted while reset is held.
  assign gnt_any = rstb & pick_any;
  assign gnt     = pick_oh & {NUM_REQ{rstb}};

  // Select the winning requester's command fields.
  always_comb begin
    win_wr   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_oh[k]) begin
        win_wr   = wr[k];
        win_addr = addr[k*N +: N];
        win_din  = din[k*N +: N];
      end
    end
  end

  // Memory port: live winner on a grant, otherwise the last granted values.
  always_comb begin
    mem_wr_ena = gnt_any & win_wr;
    mem_addr   = '0;
    mem_din    = '0;
    if (gnt_any) begin
      mem_addr = win_addr;
      mem_din  = win_din;
    end else if (rstb) begin
      mem_addr = mem_addr_q;
      mem_din  = mem_din_q;
    end
  end

  // Keep a copy of the last granted address/data so the port is stable when idle.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else if (gnt_any) begin
      mem_addr_q <= win_addr;
      mem_din_q  <= win_din;
    end
  end

`ifdef ARB_LOCK_EN
  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_lock;
  logic               win_lock;

  // Decode the lock owner for request masking.
  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      owner_oh[k] = (owner_q == ID_W'(k));
    end
  end

  // Masking depends only on registered state, so it cannot loop through the picker.
  assign req_eff    = (state_q == ARB_LOCKED) ? (req & owner_oh) : req;
  assign owner_lock = |(lock & owner_oh);
  assign win_lock   = |(lock & pick_oh);

  // Lock FSM next state; the pointer is frozen while locked and resumes after the owner.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_any) begin
          rr_ptr_d = idx_inc(pick_idx);
          if (win_lock) begin
            state_d = ARB_LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (!owner_lock) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = idx_inc(owner_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign req_eff     = req;

  // Advance the pointer past the winner on every grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = idx_inc(pick_idx);
    end
  end
`endif

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A granted read is returned next cycle; record who issued it.
  always_comb begin
    rd_pend_d = gnt_any & ~win_wr;
    rd_id_d   = gnt_any ? pick_idx : rd_id_q;
  end

  // Read-return tracking register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Strobe the originating requester; a pending return is dropped if reset arrives.
  always_comb begin
    rvalid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rvalid[k] = rstb & rd_pend_q & (rd_id_q == ID_W'(k));
    end
  end

  assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed per-cycle vector table plus
// short hand-written sequences for reset-during-read and the lock input.
module tb_mem_bus_arbiter;

  localparam int unsigned N       = 32;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ID_W    = 2;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] A2 = 32'h0000_0030;
  localparam logic [31:0] AI = 32'h4000_0004;

  logic                 clk = 1'b0;
  logic                 rstb;
  logic [NUM_REQ-1:0]   req, wr, lock;
  logic [NUM_REQ*N-1:0] addr, din;
  logic [NUM_REQ-1:0]   gnt, rvalid;
  logic [N-1:0]         rdata, mem_addr, mem_din, mem_dout;
  logic                 mem_wr_ena;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .N       (N),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req        (req),
    .wr         (wr),
    .addr       (addr),
    .din        (din),
    .lock       (lock),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .mem_wr_ena (mem_wr_ena),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Memory bus-1 model: registered read, unwritten words read as A5A500_<index>.
  logic [31:0]  mem [256];
  logic [255:0] written = '0;
  always @(posedge clk) begin
    if (rstb && (|gnt)) begin
      if (mem_wr_ena) begin
        mem[mem_addr[9:2]]     <= mem_din;
        written[mem_addr[9:2]] <= 1'b1;
      end else begin
        mem_dout <= written[mem_addr[9:2]] ? mem[mem_addr[9:2]]
                                           : {24'hA5A500, mem_addr[9:2]};
      end
    end
  end

  typedef struct {
    logic        rstb;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [2:0]  lock;
    logic [31:0] a0, a1, a2;
    logic [31:0] d0, d2;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] d0,
                              input logic [31:0] d2, input logic [2:0] eg,
                              input logic [2:0] erv, input logic ewe,
                              input logic [31:0] ea, input logic [31:0] ed,
                              input logic chk, input logic [31:0] erd);
    vec_t v;
    v.rstb = r;  v.req = rq; v.wr = w; v.lock = 3'b000;
    v.a0 = a0;   v.a1 = a1;  v.a2 = a2; v.d0 = d0; v.d2 = d2;
    v.e_gnt = eg; v.e_rv = erv; v.e_we = ewe; v.e_addr = ea; v.e_din = ed;
    v.chk_rd = chk; v.e_rd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the edge, compare outputs at the falling edge.
  task automatic run(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rstb = v.rstb;
    req  = v.req;
    wr   = v.wr;
    lock = v.lock;
    addr = {v.a2, v.a1, v.a0};
    din  = {v.d2, ~v.d0, v.d0};
    @(negedge clk);
    check({tag, " gnt"},        32'(gnt),        32'(v.e_gnt));
    check({tag, " rvalid"},     32'(rvalid),     32'(v.e_rv));
    check({tag, " mem_wr_ena"}, 32'(mem_wr_ena), 32'(v.e_we));
    check({tag, " mem_addr"},   mem_addr,        v.e_addr);
    if (v.e_we) check({tag, " mem_din"}, mem_din, v.e_din);
    if (v.chk_rd) check({tag, " rdata"}, rdata, v.e_rd);
  endtask

  vec_t tbl[22];
  vec_t v;

  initial begin
    rstb = 1'b0;
    req  = '0;
    wr   = '0;
    lock = '0;
    addr = '0;
    din  = '0;

    // Reset and idle.
    tbl[0]  = mk(0, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    // Single writer then reader.
    tbl[3]  = mk(1, 3'b001, 3'b001, A0, A1, A2, 32'hDEADBEEF, 0, 3'b001, 3'b000, 1, A0,
                 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(1, 3'b001, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b000, 0, A0, 0, 0, 0);
    tbl[5]  = mk(1, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b001, 0, A0, 0, 1,
                 32'hDEADBEEF);
    tbl[6]  = mk(1, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, A0, 0, 0, 0);
    // Re-reset so the pointer starts at 0, then all three read continuously.
    tbl[7]  = mk(0, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b000, 0, A0, 0, 0, 0);
    tbl[9]  = mk(1, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b010, 3'b001, 0, A1, 0, 1,
                 32'hDEADBEEF);
    tbl[10] = mk(1, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b100, 3'b010, 0, A2, 0, 1,
                 32'hA5A50008);
    tbl[11] = mk(1, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b100, 0, A0, 0, 1,
                 32'hA5A5000C);
    tbl[12] = mk(1, 3'b111, 3'b000, A0, A1, A2, 0, 0, 3'b010, 3'b001, 0, A1, 0, 1,
                 32'hDEADBEEF);
    // Pointer at 2 with req=011 wraps to requester 0, then 1.
    tbl[13] = mk(1, 3'b011, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b010, 0, A0, 0, 1,
                 32'hA5A50008);
    tbl[14] = mk(1, 3'b011, 3'b000, A0, A1, A2, 0, 0, 3'b010, 3'b001, 0, A1, 0, 1,
                 32'hDEADBEEF);
    tbl[15] = mk(1, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b010, 0, A1, 0, 1,
                 32'hA5A50008);
    // Instruction-space write by req2, read back by req1.
    tbl[16] = mk(1, 3'b100, 3'b100, A0, A1, AI, 0, 32'h24020005, 3'b100, 3'b000, 1, AI,
                 32'h24020005, 0, 0);
    tbl[17] = mk(1, 3'b010, 3'b000, A0, AI, AI, 0, 0, 3'b010, 3'b000, 0, AI, 0, 0, 0);
    tbl[18] = mk(1, 3'b000, 3'b000, A0, AI, AI, 0, 0, 3'b000, 3'b010, 0, AI, 0, 1,
                 32'h24020005);
    // Simultaneous write (req0) and read (req1) of the same word: grant order wins.
    tbl[19] = mk(1, 3'b011, 3'b001, AI, AI, A2, 32'h11112222, 0, 3'b001, 3'b000, 1, AI,
                 32'h11112222, 0, 0);
    tbl[20] = mk(1, 3'b010, 3'b000, AI, AI, A2, 0, 0, 3'b010, 3'b000, 0, AI, 0, 0, 0);
    tbl[21] = mk(1, 3'b000, 3'b000, AI, AI, A2, 0, 0, 3'b000, 3'b010, 0, AI, 0, 1,
                 32'h11112222);

    for (int i = 0; i < 22; i++) begin
      run(tbl[i], $sformatf("v%0d", i));
    end

    // Reset arriving while a read is in flight discards the return.
    run(mk(1, 3'b001, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b000, 0, A0, 0, 0, 0), "rst_a");
    run(mk(0, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0), "rst_b");
    run(mk(1, 3'b000, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0), "rst_c");

    // Lock input, pointer at 0 after the reset above.
    v = mk(1, 3'b011, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b000, 0, A0, 0, 0, 0);
    v.lock = 3'b001;
    run(v, "lk1");
`ifdef ARB_LOCK_EN
    v = mk(1, 3'b010, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b001, 0, A0, 0, 1, 32'hDEADBEEF);
    v.lock = 3'b001;
    run(v, "lk2");
    v = mk(1, 3'b011, 3'b000, A0, A1, A2, 0, 0, 3'b001, 3'b000, 0, A0, 0, 0, 0);
    v.lock = 3'b001;
    run(v, "lk3");
    run(mk(1, 3'b010, 3'b000, A0, A1, A2, 0, 0, 3'b000, 3'b001, 0, A0, 0, 1, 32'hDEADBEEF),
        "lk4");
    run(mk(1, 3'b010, 3'b000, A0, A1, A2, 0, 0, 3'b010, 3'b000, 0, A1, 0, 0, 0), "lk5");
`else
    // Without the lock feature the input is ignored and rotation continues.
    v = mk(1, 3'b010, 3'b000, A0, A1, A2, 0, 0, 3'b010, 3'b001, 0, A1, 0, 1, 32'hDEADBEEF);
    v.lock = 3'b001;
    run(v, "lk2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
